// File: rtl/omp_pkg.sv
// omp_pkg: shared encodings for the OMP bank controller.
//   SEL_Q / SEL_X     : h_sel load target encodings
//   SEL_V / SEL_SUPP  : rd_sel readback source encodings
//   ERR_*             : bit positions in the sticky err vector
//   state_e           : run-control FSM states
//   omp_log2          : ceil(log2(n)) for elaboration-time widths
package omp_pkg;

  localparam logic SEL_Q    = 1'b0;
  localparam logic SEL_X    = 1'b1;
  localparam logic SEL_V    = 1'b0;
  localparam logic SEL_SUPP = 1'b1;

  localparam int ERR_W      = 3;
  localparam int ERR_QOVF   = 0;
  localparam int ERR_XOVF   = 1;
  localparam int ERR_RDBUSY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int omp_log2(input int unsigned n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/omp_bank_ctrl_if.sv
// omp_bank_ctrl_if: all host, memory and HLS-core signals of the bank
// controller bundled in one interface.
//   slave  : the controller (drives h_ready, status, memory ports, readback)
//   master : the environment (host bus, RAM read data, HLS core handshake)
interface omp_bank_ctrl_if #(
  parameter int P   = 16,
  parameter int DW  = 32,
  parameter int QAW = 11,
  parameter int XAW = 8,
  parameter int RAW = 7
);
  import omp_pkg::*;

  // host load stream and control
  logic             h_valid;
  logic             h_ready;
  logic             h_sel;
  logic [DW-1:0]    h_data;
  logic             h_clr;
  logic             start;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err;
  logic             host_own;
  // memory write ports
  logic [P-1:0]     q_we;
  logic [QAW-1:0]   q_addr;
  logic [DW-1:0]    q_din;
  logic             x_we;
  logic [XAW-1:0]   x_addr;
  logic [DW-1:0]    x_din;
  // HLS core handshake
  logic             core_start;
  logic             core_done;
  logic             core_idle;
  // readback
  logic             rd_req;
  logic             rd_sel;
  logic [RAW-1:0]   rd_addr;
  logic [RAW-1:0]   rb_addr;
  logic [DW-1:0]    v_q;
  logic [DW-1:0]    supp_q;
  logic             rd_valid;
  logic [DW-1:0]    rd_data;

  modport slave (
    input  h_valid, h_sel, h_data, h_clr, start,
    input  core_done, core_idle,
    input  rd_req, rd_sel, rd_addr, v_q, supp_q,
    output h_ready, busy, done, err, host_own,
    output q_we, q_addr, q_din, x_we, x_addr, x_din,
    output core_start, rb_addr, rd_valid, rd_data
  );

  modport master (
    output h_valid, h_sel, h_data, h_clr, start,
    output core_done, core_idle,
    output rd_req, rd_sel, rd_addr, v_q, supp_q,
    input  h_ready, busy, done, err, host_own,
    input  q_we, q_addr, q_din, x_we, x_addr, x_din,
    input  core_start, rb_addr, rd_valid, rd_data
  );

endinterface

// File: rtl/omp_load_addr.sv
// omp_load_addr: saturating load-address counter with an AW+1 bit count.
// The MSB is the full flag (count == 2^AW); o_idx is the in-range index.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : zero the counter (wins over i_inc)
//   i_inc      : a word is offered at the current index
//   o_idx      : current write index
//   o_wr       : word accepted at o_idx (counter advances)
//   o_ovf      : word offered while full (dropped, counter holds)
module omp_load_addr #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [AW-1:0] o_idx,
  output logic          o_wr,
  output logic          o_ovf
);

  logic [AW:0] r_cnt;
  logic        w_full;

  assign w_full = r_cnt[AW];
  assign o_idx  = r_cnt[AW-1:0];
  assign o_wr   = i_inc & ~i_clr & ~w_full;
  assign o_ovf  = i_inc & ~i_clr & w_full;

  // once the MSB is set the low bits are zero and no further increment
  // happens, so the count saturates at exactly 2^AW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (o_wr) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/omp_bank_ctrl.sv
// omp_bank_ctrl: host-side controller for the OMP accelerator.
// Loads Q (interleaved across P banks) and X from a valid/ready stream,
// runs the HLS core through core_start/core_done, and serves pipelined
// V/supp readback with a fixed two-cycle latency.
//   clk, rst_n : clock, async active-low reset (also resets the core)
//   bus        : omp_bank_ctrl_if.slave, host/memory/core signals
//
// state | meaning
// IDLE  | memories owned by host, no run since reset or h_clr
// RUN   | core running, host loads and readback blocked
// DONE  | last run finished, results readable, host owns memories
module omp_bank_ctrl
  import omp_pkg::*;
#(
  parameter int P   = 16,
  parameter int DW  = 32,
  parameter int QAW = 11,
  parameter int XAW = 8,
  parameter int RAW = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  omp_bank_ctrl_if.slave    bus
);

  localparam int LP  = omp_log2(P);
  localparam int QIW = LP + QAW;

  state_e           r_state;
  logic             r_h_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_host_own;
  logic             r_core_start;
  logic [ERR_W-1:0] r_err;

  logic [P-1:0]     r_q_we;
  logic [QAW-1:0]   r_q_addr;
  logic [DW-1:0]    r_q_din;
  logic             r_x_we;
  logic [XAW-1:0]   r_x_addr;
  logic [DW-1:0]    r_x_din;

  logic             r_rd_p1;
  logic             r_rd_valid;
  logic             r_sel_p1;
  logic             r_sel_p2;
  logic [RAW-1:0]   r_rb_addr;

  logic             w_host_side;
  logic             w_clr;
  logic             w_xfer;
  logic             w_q_inc;
  logic             w_x_inc;
  logic             w_q_wr;
  logic             w_q_ovf;
  logic             w_x_wr;
  logic             w_x_ovf;
  logic             w_rd_acc;
  logic [QIW-1:0]   w_q_idx;
  logic [QIW-1:0]   w_q_bank;
  logic [QAW-1:0]   w_q_row;
  logic [XAW-1:0]   w_x_idx;

  assign w_host_side = (r_state != RUN);
  assign w_clr       = bus.h_clr & w_host_side;
  assign w_xfer      = bus.h_valid & r_h_ready;
  assign w_q_inc     = w_xfer & (bus.h_sel == SEL_Q);
  assign w_x_inc     = w_xfer & (bus.h_sel == SEL_X);
  assign w_rd_acc    = bus.rd_req & w_host_side;

  omp_load_addr #(.AW(QIW)) u_q_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_inc (w_q_inc),
    .o_idx (w_q_idx),
    .o_wr  (w_q_wr),
    .o_ovf (w_q_ovf)
  );

  omp_load_addr #(.AW(XAW)) u_x_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_inc (w_x_inc),
    .o_idx (w_x_idx),
    .o_wr  (w_x_wr),
    .o_ovf (w_x_ovf)
  );

  // flat index n -> bank n mod P, row n / P (P is a power of two)
  assign w_q_bank = w_q_idx & QIW'(P - 1);
  assign w_q_row  = QAW'(w_q_idx >> LP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_h_ready    <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_host_own   <= 1'b1;
      r_core_start <= 1'b0;
      r_err        <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_clr) begin
            r_done <= 1'b0;
            r_err  <= '0;
          end
          if (w_q_ovf) r_err[ERR_QOVF] <= 1'b1;
          if (w_x_ovf) r_err[ERR_XOVF] <= 1'b1;
          if (bus.start) begin
            r_state      <= RUN;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_host_own   <= 1'b0;
            r_h_ready    <= 1'b0;
            r_core_start <= 1'b1;
          end
        end
        RUN: begin
          if (bus.rd_req) r_err[ERR_RDBUSY] <= 1'b1;
          // ap_start is held until the core has visibly left idle
          if (r_core_start && !bus.core_idle) r_core_start <= 1'b0;
          if (bus.core_done) begin
            r_state      <= DONE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_host_own   <= 1'b1;
            r_h_ready    <= 1'b1;
            r_core_start <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_we   <= '0;
      r_q_addr <= '0;
      r_q_din  <= '0;
      r_x_we   <= 1'b0;
      r_x_addr <= '0;
      r_x_din  <= '0;
    end else begin
      r_q_we <= '0;
      r_x_we <= 1'b0;
      if (w_q_wr) begin
        r_q_we   <= P'(1) << w_q_bank;
        r_q_addr <= w_q_row;
        r_q_din  <= bus.h_data;
      end
      if (w_x_wr) begin
        r_x_we   <= 1'b1;
        r_x_addr <= w_x_idx;
        r_x_din  <= bus.h_data;
      end
    end
  end

  // rb_addr is registered at t, the RAM registers its output at t+1, so the
  // RAM output register is already valid when rd_valid rises at t+2. A
  // request accepted just before a start still completes for that reason.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rb_addr  <= '0;
      r_rd_p1    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_sel_p1   <= 1'b0;
      r_sel_p2   <= 1'b0;
    end else begin
      r_rd_p1    <= w_rd_acc;
      r_rd_valid <= r_rd_p1;
      r_sel_p2   <= r_sel_p1;
      if (w_rd_acc) begin
        r_rb_addr <= bus.rd_addr;
        r_sel_p1  <= bus.rd_sel;
      end
    end
  end

  assign bus.h_ready    = r_h_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.host_own   = r_host_own;
  assign bus.q_we       = r_q_we;
  assign bus.q_addr     = r_q_addr;
  assign bus.q_din      = r_q_din;
  assign bus.x_we       = r_x_we;
  assign bus.x_addr     = r_x_addr;
  assign bus.x_din      = r_x_din;
  assign bus.core_start = r_core_start;
  assign bus.rb_addr    = r_rb_addr;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_data    = r_rd_valid ? ((r_sel_p2 == SEL_SUPP) ? bus.supp_q : bus.v_q) : '0;

endmodule

// File: tb/tb_omp_bank_ctrl.sv
// tb_omp_bank_ctrl: directed test of omp_bank_ctrl with P=4, QAW=2, XAW=3.
// A behavioural RAM returns {16'hA5A5, rb_addr} on v_q and {16'h5A5A, rb_addr}
// on supp_q one cycle after the address.
module tb_omp_bank_ctrl;

  localparam int P   = 4;
  localparam int DW  = 32;
  localparam int QAW = 2;
  localparam int XAW = 3;
  localparam int RAW = 7;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;
  int   busy_cyc;
  logic [3:0] exp_we;

  omp_bank_ctrl_if #(.P(P), .DW(DW), .QAW(QAW), .XAW(XAW), .RAW(RAW)) bus ();

  omp_bank_ctrl #(.P(P), .DW(DW), .QAW(QAW), .XAW(XAW), .RAW(RAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.v_q    <= {16'hA5A5, 9'd0, bus.rb_addr};
    bus.supp_q <= {16'h5A5A, 9'd0, bus.rb_addr};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    bus.h_valid = 1'b0; bus.h_sel = 1'b0; bus.h_data = '0; bus.h_clr = 1'b0;
    bus.start = 1'b0; bus.core_done = 1'b0; bus.core_idle = 1'b1;
    bus.rd_req = 1'b0; bus.rd_sel = 1'b0; bus.rd_addr = '0;
    #12;
    chk("rst h_ready", 64'(bus.h_ready), 64'd1);
    chk("rst host_own", 64'(bus.host_own), 64'd1);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst err", 64'(bus.err), 64'd0);
    chk("rst q_we", 64'(bus.q_we), 64'd0);
    chk("rst core_start", 64'(bus.core_start), 64'd0);
    chk("rst rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst rd_data", 64'(bus.rd_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // Q stream: 16 words fill 4 banks x 4 rows, the 17th overflows
    bus.h_sel = 1'b0;
    bus.h_valid = 1'b1;
    for (int n = 0; n < 17; n++) begin
      bus.h_data = 32'h100 + 32'(n);
      tick();
      if (n < 16) begin
        exp_we = 4'b0001 << (n % 4);
        chk("q_we", 64'(bus.q_we), 64'(exp_we));
        chk("q_addr", 64'(bus.q_addr), 64'(n / 4));
        chk("q_din", 64'(bus.q_din), 64'(32'h100 + 32'(n)));
      end else begin
        chk("q_we ovf", 64'(bus.q_we), 64'd0);
        chk("err qovf", 64'(bus.err), 64'b001);
      end
    end
    bus.h_valid = 1'b0;
    tick();
    chk("q_we idle", 64'(bus.q_we), 64'd0);

    bus.h_clr = 1'b1;
    tick();
    bus.h_clr = 1'b0;
    chk("err clr", 64'(bus.err), 64'd0);

    // X: 5 words, clear racing a word, then a fresh word lands at 0
    bus.h_sel = 1'b1;
    bus.h_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      bus.h_data = 32'h200 + 32'(n);
      tick();
      chk("x_we", 64'(bus.x_we), 64'd1);
      chk("x_addr", 64'(bus.x_addr), 64'(n));
    end
    bus.h_clr = 1'b1;
    bus.h_data = 32'hDEAD;
    tick();
    bus.h_clr = 1'b0;
    chk("x_we clr drop", 64'(bus.x_we), 64'd0);
    bus.h_data = 32'h300;
    tick();
    chk("x_we post clr", 64'(bus.x_we), 64'd1);
    chk("x_addr post clr", 64'(bus.x_addr), 64'd0);
    chk("x_din post clr", 64'(bus.x_din), 64'h300);
    chk("err post clr", 64'(bus.err), 64'd0);
    for (int n = 1; n < 8; n++) begin
      bus.h_data = 32'h300 + 32'(n);
      tick();
      chk("x_addr fill", 64'(bus.x_addr), 64'(n));
    end
    bus.h_data = 32'h3FF;
    tick();
    chk("x_we ovf", 64'(bus.x_we), 64'd0);
    chk("err xovf", 64'(bus.err), 64'b010);
    bus.h_valid = 1'b0;
    bus.h_clr = 1'b1;
    tick();
    bus.h_clr = 1'b0;
    chk("err clr2", 64'(bus.err), 64'd0);

    // run: start, core leaves idle, core_done after the 10th busy cycle
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("run busy", 64'(bus.busy), 64'd1);
    chk("run host_own", 64'(bus.host_own), 64'd0);
    chk("run core_start", 64'(bus.core_start), 64'd1);
    chk("run h_ready", 64'(bus.h_ready), 64'd0);
    busy_cyc = bus.busy ? 1 : 0;
    bus.h_sel = 1'b0;
    bus.h_valid = 1'b1;
    bus.h_data = 32'h400;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      if (bus.busy) busy_cyc++;
      chk("run q_we", 64'(bus.q_we), 64'd0);
      if (i == 1) begin
        chk("core_start held", 64'(bus.core_start), 64'd1);
        bus.core_idle = 1'b0;
      end
      if (i == 2) chk("core_start drop", 64'(bus.core_start), 64'd0);
      if (i == 3) chk("err rd busy", 64'(bus.err), 64'b100);
      if (i == 4 || i == 5) chk("rd_valid in run", 64'(bus.rd_valid), 64'd0);
    end
    bus.core_done = 1'b1;
    bus.core_idle = 1'b1;
    tick();
    bus.core_done = 1'b0;
    if (bus.busy) busy_cyc++;
    chk("busy cycles", 64'(busy_cyc), 64'd11);
    chk("done", 64'(bus.done), 64'd1);
    chk("done host_own", 64'(bus.host_own), 64'd1);
    chk("done h_ready", 64'(bus.h_ready), 64'd1);
    chk("done q_we", 64'(bus.q_we), 64'd0);
    tick();
    chk("resume q_we", 64'(bus.q_we), 64'b0001);
    chk("resume q_addr", 64'(bus.q_addr), 64'd0);
    chk("resume q_din", 64'(bus.q_din), 64'h400);
    bus.h_valid = 1'b0;

    // readback, back-to-back V then supp
    bus.rd_req = 1'b1; bus.rd_sel = 1'b0; bus.rd_addr = 7'd3;
    tick();
    chk("rb_addr", 64'(bus.rb_addr), 64'd3);
    chk("rd_valid t+1", 64'(bus.rd_valid), 64'd0);
    bus.rd_sel = 1'b1; bus.rd_addr = 7'd5;
    tick();
    bus.rd_req = 1'b0;
    chk("rd_valid v", 64'(bus.rd_valid), 64'd1);
    chk("rd_data v", 64'(bus.rd_data), 64'hA5A5_0003);
    tick();
    chk("rd_valid supp", 64'(bus.rd_valid), 64'd1);
    chk("rd_data supp", 64'(bus.rd_data), 64'h5A5A_0005);
    tick();
    chk("rd_valid end", 64'(bus.rd_valid), 64'd0);
    chk("rd_data end", 64'(bus.rd_data), 64'd0);
    chk("done sticky", 64'(bus.done), 64'd1);

    // readback in flight when start arrives
    bus.rd_req = 1'b1; bus.rd_sel = 1'b0; bus.rd_addr = 7'd9;
    bus.start = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    bus.start = 1'b0;
    chk("inflight host_own", 64'(bus.host_own), 64'd0);
    chk("inflight rb_addr", 64'(bus.rb_addr), 64'd9);
    tick();
    chk("inflight rd_valid", 64'(bus.rd_valid), 64'd1);
    chk("inflight rd_data", 64'(bus.rd_data), 64'hA5A5_0009);
    chk("inflight err", 64'(bus.err), 64'b100);

    // async reset mid-run
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", 64'(bus.busy), 64'd0);
    chk("arst core_start", 64'(bus.core_start), 64'd0);
    chk("arst host_own", 64'(bus.host_own), 64'd1);
    chk("arst h_ready", 64'(bus.h_ready), 64'd1);
    chk("arst err", 64'(bus.err), 64'd0);
    chk("arst rb_addr", 64'(bus.rb_addr), 64'd0);
    #2 rst_n = 1'b1;
    tick();

    // async reset mid-load, then the next word restarts at bank 0 row 0
    bus.h_sel = 1'b0;
    bus.h_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      bus.h_data = 32'h500 + 32'(n);
      tick();
    end
    chk("mid-load q_we", 64'(bus.q_we), 64'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst q_we", 64'(bus.q_we), 64'd0);
    chk("arst q_addr", 64'(bus.q_addr), 64'd0);
    bus.h_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    bus.h_valid = 1'b1;
    bus.h_data = 32'h600;
    tick();
    bus.h_valid = 1'b0;
    chk("post-rst q_we", 64'(bus.q_we), 64'b0001);
    chk("post-rst q_addr", 64'(bus.q_addr), 64'd0);
    chk("post-rst q_din", 64'(bus.q_din), 64'h600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/omp_bank_ctrl.md
# omp_bank_ctrl

Parametrised host-side controller for the OMP accelerator. It sits between the host bus and the banked dictionary memories (Q), the signal memory (X) and the result memories (V, supp). It replaces fixed-width address slicing with a valid/ready load stream, auto-incrementing interleaved addressing across P banks, a run-control FSM around the HLS core's ap_start/ap_done, and a latency-aligned readback port with sticky error flags.

## Interface
- P, 16: number of Q banks; power of two, 1..64.
- DW, 32: data word width.
- QAW, 11: per-bank Q address width.
- XAW, 8: X address width.
- RAW, 7: V/supp address width.
- clk in 1: single clock, rising edge.
- rst_n in 1: asynchronous, active-low reset.
- h_valid in 1: host load word valid.
- h_ready out 1: controller accepts the load word.
- h_sel in 1: load target; 0 = Q, 1 = X.
- h_data in DW: load word.
- h_clr in 1: pulse; zeroes both load counters and clears done/err.
- start in 1: run request pulse.
- busy out 1: core run in progress.
- done out 1: sticky, last run completed.
- err out 3: sticky; [0] Q overflow, [1] X overflow, [2] readback while busy.
- host_own out 1: 1 = memories muxed to host side; drives the wrapper's RAM address/we/din muxes.
- q_we out P: per-bank write enable.
- q_addr out QAW: shared bank row address.
- q_din out DW: Q write data.
- x_we out 1, x_addr out XAW, x_din out DW: X write port.
- core_start out 1, core_done in 1, core_idle in 1: HLS control handshake.
- rd_req in 1, rd_sel in 1 (0 = V, 1 = supp), rd_addr in RAW: readback request.
- rb_addr out RAW: host-side V/supp address.
- v_q in DW, supp_q in DW: RAM read data (1-cycle latency).
- rd_valid out 1, rd_data out DW: readback response.

## Operation
- FSM states: IDLE, RUN, DONE. Reset: IDLE; all outputs 0 except h_ready = 1 and host_own = 1.
- Load is legal in IDLE and DONE. h_ready = 1 outside RUN; a word transfers when h_valid && h_ready.
- Q load: flat counter qc (width log2(P)+QAW+1). The word goes to bank qc mod P, row qc / P; q_we one-hot, registered, asserted for exactly one cycle. qc then increments.
- Q overflow: when qc == P*2^QAW, the word is dropped (no q_we) and err[0] is set. qc saturates.
- X load: counter xc with the same rules against 2^XAW; err[1] on overflow.
- h_clr takes priority over a same-cycle transfer: counters are zeroed, the word is dropped, and done and err are cleared. In RUN, h_clr is ignored.
- start in IDLE/DONE: transition to RUN; clear done; busy = 1; host_own = 0; core_start = 1, held until the cycle after core_idle is seen low.
- start in RUN is ignored.
- In RUN, core_done = 1 → DONE: busy = 0, done = 1, host_own = 1.
- Readback (IDLE/DONE only): on rd_req, rb_addr is registered and the RAM output is captured one cycle later. rd_data is the registered v_q or supp_q selected by the registered rd_sel.
- rd_req in RUN: no rd_valid, err[2] set.
- Back-to-back rd_req is allowed every cycle (fully pipelined).

## Timing
- Load write: q_we/x_we assert 1 cycle after the handshake cycle. Throughput is 1 word per cycle.
- start → core_start: 1 cycle. core_done → done: 1 cycle. host_own follows busy with no extra delay.
- Readback latency: rd_req at cycle t → rd_valid at t+2.
- An in-flight readback when start arrives completes normally: rb_addr is already latched, and host_own drops at t+1 while data is captured at t+2 from the RAM output register.
- rst_n assertion mid-run returns to IDLE immediately and core_start deasserts. The core must be reset by the same rst_n.

## Structure
- Package omp_pkg holds: target encodings (SEL_Q, SEL_X, SEL_V, SEL_SUPP), err bit indices, FSM state enum, and the log2 helper function.
- One sub-module, omp_load_addr: a parametrised counter with saturation and overflow flag. It is instantiated twice, for Q (split into bank/row) and X.

## Test plan
- P=4, QAW=2: stream 16 Q words 0..15 → word n writes bank n%4, row n/4. The 17th word gives no q_we and err = 3'b001.
- Load 5 X words, then h_clr, then 1 X word → x_addr = 0 for the last write; err = 0.
- start with core_done pulse 10 cycles later → busy 1 for 11 cycles, core_start held until core_idle low, done = 1, host_own back to 1.
- Readback V addr 3 (v_q = 0xA5A5_0003) at t → rd_valid and rd_data = 0xA5A5_0003 at t+2. rd_req during RUN gives no rd_valid and err[2] = 1.
- h_valid high throughout RUN → h_ready = 0 and no q_we; loading resumes the cycle after done.
- rst_n low mid-RUN and mid-load → all outputs return to their reset values asynchronously. A post-reset load starts at bank 0, row 0.
